// File: rtl/vram_addr_if.sv
// vram_addr_if: CPU register port and VRAM bus of the PPU address unit.
interface vram_addr_if;
  logic        reg_wr;
  logic        reg_rd;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic        vram_wr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  modport master (
    output reg_wr, reg_rd, reg_sel, reg_din, vram_rdata,
    input  reg_dout, vram_addr, vram_rd, vram_wr, vram_wdata
  );
  modport slave (
    input  reg_wr, reg_rd, reg_sel, reg_din, vram_rdata,
    output reg_dout, vram_addr, vram_rd, vram_wr, vram_wdata
  );
endinterface

// File: rtl/vram_addr.sv
// vram_addr: PPU loopy v/t scroll registers, CPU register decode and VRAM address/strobe generation.
module vram_addr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rend,
  input  logic        fetch_nt,
  input  logic        fetch_attr,
  input  logic        fetch_chr,
  input  logic [12:0] pattern_idx,
  input  logic        inc_cx,
  input  logic        inc_y,
  input  logic        return00,
  output logic [2:0]  fine_x,
  output logic [7:0]  data_o,
  output logic [1:0]  attr_o,
  vram_addr_if.slave  bus
);
  logic [14:0] v, t, v_n, t_n;
  logic        w, w_n, inc32, inc32_n;
  logic [2:0]  fx_n, attr_sh;
  logic [7:0]  rbuf;
  logic        rd_pend, attr_pend;
  logic [1:0]  attr_q, attr_now;
  logic        fetch, data_acc;
  assign fetch = fetch_nt | fetch_attr | fetch_chr;
  // PPUDATA only reaches memory outside rendering and never over a renderer fetch
  assign data_acc = !rend && !fetch && bus.reg_sel == 3'd7 && (bus.reg_wr || bus.reg_rd);
  assign attr_now = bus.vram_rdata[attr_sh +: 2];
  assign attr_o = attr_pend ? attr_now : attr_q;
  assign data_o = bus.vram_rdata;
  assign bus.reg_dout = bus.reg_sel == 3'd7 ? rbuf : 8'h00;
  assign bus.vram_wdata = bus.reg_din;
  assign bus.vram_rd = rst_n & (fetch | (data_acc & bus.reg_rd));
  assign bus.vram_wr = rst_n & data_acc & bus.reg_wr;
  assign bus.vram_addr = fetch_nt   ? {2'b10, v[11:0]} :
                         fetch_attr ? {2'b10, v[11:10], 4'b1111, v[9:7], v[4:2]} :
                         fetch_chr  ? {1'b0, pattern_idx} : v[13:0];
  always_comb begin
    t_n = t;
    v_n = v;
    w_n = w;
    fx_n = fine_x;
    inc32_n = inc32;
    if (bus.reg_wr && bus.reg_sel == 3'd0) begin
      t_n[11:10] = bus.reg_din[1:0];
      inc32_n = bus.reg_din[2];
    end
    if (bus.reg_rd && bus.reg_sel == 3'd2) w_n = 1'b0;
    if (bus.reg_wr && bus.reg_sel == 3'd5) begin
      if (!w) begin
        t_n[4:0] = bus.reg_din[7:3];
        fx_n = bus.reg_din[2:0];
      end else begin
        t_n[14:12] = bus.reg_din[2:0];
        t_n[9:5] = bus.reg_din[7:3];
      end
      w_n = !w;
    end
    if (bus.reg_wr && bus.reg_sel == 3'd6) begin
      if (!w) begin
        t_n[13:8] = bus.reg_din[5:0];
        t_n[14] = 1'b0;
      end else begin
        t_n[7:0] = bus.reg_din;
        v_n = t_n;
      end
      w_n = !w;
    end
    if (data_acc) v_n = v + (inc32 ? 15'd32 : 15'd1);
    // coarse X wraps naturally in 5 bits; only the NT toggle needs the compare
    if (rend && inc_cx) begin
      v_n[10] = v_n[4:0] == 5'd31 ? ~v_n[10] : v_n[10];
      v_n[4:0] = v_n[4:0] + 5'd1;
    end
    if (rend && inc_y) begin
      if (v_n[14:12] != 3'd7) v_n[14:12] = v_n[14:12] + 3'd1;
      else begin
        v_n[14:12] = 3'd0;
        v_n[11] = v_n[9:5] == 5'd29 ? ~v_n[11] : v_n[11];
        v_n[9:5] = v_n[9:5] == 5'd29 ? 5'd0 : v_n[9:5] + 5'd1;
      end
      v_n[10] = t[10];
      v_n[4:0] = t[4:0];
    end
    if (rend && return00) begin
      v_n[14:11] = t[14:11];
      v_n[9:5] = t[9:5];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      t <= '0;
      w <= 1'b0;
      fine_x <= '0;
      inc32 <= 1'b0;
      rbuf <= '0;
      rd_pend <= 1'b0;
      attr_pend <= 1'b0;
      attr_sh <= '0;
      attr_q <= '0;
    end else begin
      v <= v_n;
      t <= t_n;
      w <= w_n;
      fine_x <= fx_n;
      inc32 <= inc32_n;
      rd_pend <= data_acc & bus.reg_rd;
      rbuf <= rd_pend ? bus.vram_rdata : rbuf;
      attr_pend <= fetch_attr;
      attr_sh <= fetch_attr ? {v[6], v[1], 1'b0} : attr_sh;
      attr_q <= attr_pend ? attr_now : attr_q;
    end
  end
endmodule

// File: tb/tb_vram_addr.sv
// tb_vram_addr: directed stimulus with a cycle-stamped scoreboard checked by a separate monitor.
module tb_vram_addr;
  localparam int S_ADDR = 0, S_RD = 1, S_WR = 2, S_WDATA = 3, S_DOUT = 4, S_ATTR = 5,
                 S_FX = 6, S_DATA = 7, S_T = 8, S_W = 9, S_V = 10;
  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] val;
    string       nm;
  } exp_t;
  logic clk, rst_n, rend, fetch_nt, fetch_attr, fetch_chr, inc_cx, inc_y, return00;
  logic [12:0] pattern_idx;
  logic [2:0]  fine_x;
  logic [7:0]  data_o;
  logic [1:0]  attr_o;
  logic [7:0]  mem [0:16383];
  exp_t sb[$];
  int cyc = 0, n_run = 0, n_fail = 0;
  event probe;
  vram_addr_if bus();
  vram_addr dut (
    .clk(clk), .rst_n(rst_n), .rend(rend), .fetch_nt(fetch_nt), .fetch_attr(fetch_attr),
    .fetch_chr(fetch_chr), .pattern_idx(pattern_idx), .inc_cx(inc_cx), .inc_y(inc_y),
    .return00(return00), .fine_x(fine_x), .data_o(data_o), .attr_o(attr_o), .bus(bus)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (bus.vram_wr) mem[bus.vram_addr] <= bus.vram_wdata;
    if (bus.vram_rd) bus.vram_rdata <= mem[bus.vram_addr];
  end
  function automatic logic [15:0] actual(int sig);
    case (sig)
      S_ADDR:  return {2'b0, bus.vram_addr};
      S_RD:    return {15'b0, bus.vram_rd};
      S_WR:    return {15'b0, bus.vram_wr};
      S_WDATA: return {8'b0, bus.vram_wdata};
      S_DOUT:  return {8'b0, bus.reg_dout};
      S_ATTR:  return {14'b0, attr_o};
      S_FX:    return {13'b0, fine_x};
      S_DATA:  return {8'b0, data_o};
      S_T:     return {1'b0, dut.t};
      S_W:     return {15'b0, dut.w};
      default: return {1'b0, dut.v};
    endcase
  endfunction
  function automatic void exp_at(int dc, int sig, logic [15:0] val, string nm);
    sb.push_back('{cyc + dc, sig, val, nm});
  endfunction
  task automatic scan();
    int i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        logic [15:0] a = actual(sb[i].sig);
        n_run++;
        if (a !== sb[i].val) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h (cycle %0d)", sb[i].nm, a, sb[i].val, cyc);
        end
        sb.delete(i);
      end else i++;
    end
  endtask
  always @(negedge clk) scan();
  always @(probe) scan();
  task automatic nxt();
    @(posedge clk);
    #1;
    bus.reg_wr = 0; bus.reg_rd = 0; bus.reg_sel = 0;
    fetch_nt = 0; fetch_attr = 0; fetch_chr = 0;
    inc_cx = 0; inc_y = 0; return00 = 0;
  endtask
  task automatic wr(input logic [2:0] s, input logic [7:0] d);
    nxt();
    bus.reg_sel = s; bus.reg_din = d; bus.reg_wr = 1;
  endtask
  task automatic rd(input logic [2:0] s);
    nxt();
    bus.reg_sel = s; bus.reg_rd = 1;
  endtask
  task automatic do_reset();
    nxt();
    nxt(); rst_n = 0; rend = 0;
    nxt();
    nxt(); rst_n = 1;
  endtask
  initial begin
    rst_n = 0; rend = 0; pattern_idx = 0; bus.reg_din = 0;
    bus.reg_wr = 0; bus.reg_rd = 0; bus.reg_sel = 0;
    fetch_nt = 0; fetch_attr = 0; fetch_chr = 0; inc_cx = 0; inc_y = 0; return00 = 0;
    nxt();
    nxt(); bus.reg_sel = 7;
    exp_at(0, S_V, 0, "rst_v"); exp_at(0, S_T, 0, "rst_t"); exp_at(0, S_W, 0, "rst_w");
    exp_at(0, S_FX, 0, "rst_fx"); exp_at(0, S_RD, 0, "rst_rd"); exp_at(0, S_WR, 0, "rst_wr");
    exp_at(0, S_DOUT, 0, "rst_dout"); exp_at(0, S_ATTR, 0, "rst_attr");
    nxt(); rst_n = 1;
    // PPUADDR then PPUDATA writes, +1 and +32 increments
    wr(6, 8'h21); wr(6, 8'h08);
    nxt(); exp_at(0, S_ADDR, 16'h2108, "ppuaddr_v");
    wr(7, 8'h5A);
    exp_at(0, S_ADDR, 16'h2108, "wr_addr"); exp_at(0, S_WR, 1, "wr_strobe");
    exp_at(0, S_WDATA, 16'h5A, "wr_data"); exp_at(0, S_RD, 0, "wr_no_rd");
    exp_at(1, S_ADDR, 16'h2109, "wr_inc1");
    wr(0, 8'h04); wr(6, 8'h21); wr(6, 8'h08); wr(7, 8'h5A);
    exp_at(1, S_ADDR, 16'h2128, "wr_inc32");
    // PPUSCROLL pair
    do_reset();
    wr(5, 8'h7D); exp_at(1, S_FX, 5, "scroll_fx"); exp_at(1, S_W, 1, "scroll_w1");
    wr(5, 8'h5E); exp_at(1, S_T, 16'h616F, "scroll_t"); exp_at(1, S_W, 0, "scroll_w0");
    // scroll increments
    do_reset();
    wr(6, 8'h00); wr(6, 8'h1F);
    nxt(); rend = 1; inc_cx = 1; exp_at(1, S_ADDR, 16'h0400, "inc_cx_wrap");
    wr(5, 8'hF8); wr(5, 8'hEF);
    nxt(); return00 = 1; exp_at(1, S_V, 16'h77A0, "return00_a");
    nxt(); inc_y = 1; exp_at(1, S_V, 16'h081F, "inc_y_cy29");
    wr(5, 8'h00); wr(5, 8'hFF);
    nxt(); return00 = 1; exp_at(1, S_V, 16'h73FF, "return00_b");
    nxt(); inc_y = 1; exp_at(1, S_V, 16'h0000, "inc_y_cy31");
    // renderer fetches
    do_reset();
    wr(6, 8'h23); wr(6, 8'hC1); wr(7, 8'hC0); wr(6, 8'h00); wr(6, 8'h66);
    nxt(); rend = 1; fetch_attr = 1;
    exp_at(0, S_ADDR, 16'h23C1, "attr_addr"); exp_at(0, S_RD, 1, "attr_rd");
    exp_at(1, S_ATTR, 3, "attr_o"); exp_at(1, S_DATA, 16'hC0, "attr_data");
    nxt(); fetch_nt = 1; exp_at(0, S_ADDR, 16'h2066, "nt_addr");
    nxt(); fetch_chr = 1; pattern_idx = 13'h1ABC;
    exp_at(0, S_ADDR, 16'h1ABC, "chr_addr"); exp_at(0, S_ATTR, 3, "attr_hold");
    // PPUDATA reads via the buffer, blocked write while rendering, status clears w
    do_reset();
    wr(6, 8'h21); wr(6, 8'h08); wr(7, 8'h11); wr(7, 8'h22); wr(6, 8'h21); wr(6, 8'h08);
    rd(7);
    exp_at(0, S_ADDR, 16'h2108, "rd1_addr"); exp_at(0, S_RD, 1, "rd1_strobe");
    exp_at(0, S_DOUT, 16'h00, "rd1_dout");
    nxt();
    rd(7); exp_at(0, S_ADDR, 16'h2109, "rd2_addr"); exp_at(0, S_DOUT, 16'h11, "rd2_dout");
    nxt();
    nxt(); bus.reg_sel = 7; rend = 1; exp_at(0, S_DOUT, 16'h22, "buf_after_rd2");
    wr(7, 8'h99);
    exp_at(0, S_WR, 0, "rend_no_wr"); exp_at(0, S_RD, 0, "rend_no_rd");
    exp_at(1, S_ADDR, 16'h210A, "rend_v_hold");
    nxt(); rend = 0;
    wr(6, 8'h3F); exp_at(1, S_W, 1, "addr_w1");
    rd(2); exp_at(1, S_W, 0, "status_clr_w");
    // asynchronous reset in the middle of a pattern fetch
    do_reset();
    wr(5, 8'h7D);
    nxt(); rend = 1; fetch_chr = 1; pattern_idx = 13'h0123; bus.reg_sel = 7;
    exp_at(0, S_RD, 1, "chr_rd"); exp_at(0, S_FX, 5, "pre_rst_fx");
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    exp_at(0, S_RD, 0, "arst_rd"); exp_at(0, S_FX, 0, "arst_fx"); exp_at(0, S_T, 0, "arst_t");
    exp_at(0, S_W, 0, "arst_w"); exp_at(0, S_V, 0, "arst_v"); exp_at(0, S_DOUT, 0, "arst_dout");
    exp_at(0, S_ATTR, 0, "arst_attr");
    ->probe;
    nxt(); rend = 0;
    nxt(); rst_n = 1;
    exp_at(0, S_RD, 0, "post_rel_rd"); exp_at(0, S_ADDR, 0, "post_rel_addr");
    nxt();
    nxt();
    if (sb.size() != 0) begin
      n_fail += sb.size();
      $display("FAIL scoreboard: %0d unchecked entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
